// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS frequency-control word from a start
// word to a stop word, holding each word for a programmable dwell time.
module dds_sweep_ctrl #(
    parameter int FW = 11,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [FW-1:0] cfg_start,
    input  logic [FW-1:0] cfg_stop,
    input  logic [FW-1:0] cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic          cfg_cont,
    input  logic          go,
    input  logic          abort,
    output logic [FW-1:0] freq_ctrl,
    output logic          step_stb,
    output logic          busy,
    output logic          wrap,
    output logic          sweep_done
);

    typedef enum logic [1:0] {IDLE, ARMED, SWEEP, DONE} state_t;

    state_t        state_reg, state_next;
    logic [FW-1:0] start_reg, start_next;
    logic [FW-1:0] stop_reg, stop_next;
    logic [FW-1:0] step_reg, step_next;
    logic [DW-1:0] dwell_reg, dwell_next;
    logic          cont_reg, cont_next;
    logic [DW-1:0] cnt_reg, cnt_next;
    logic [FW-1:0] freq_reg, freq_next;
    logic          stb_reg, stb_next;
    logic          wrap_reg, wrap_next;

    // One extra bit so a step past the top of the word range is seen as > stop
    // instead of wrapping to a low frequency.
    logic [FW:0]   sum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            start_reg <= '0;
            stop_reg  <= '0;
            step_reg  <= '0;
            dwell_reg <= '0;
            cont_reg  <= 1'b0;
            cnt_reg   <= '0;
            freq_reg  <= '0;
            stb_reg   <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            start_reg <= start_next;
            stop_reg  <= stop_next;
            step_reg  <= step_next;
            dwell_reg <= dwell_next;
            cont_reg  <= cont_next;
            cnt_reg   <= cnt_next;
            freq_reg  <= freq_next;
            stb_reg   <= stb_next;
            wrap_reg  <= wrap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        start_next = start_reg;
        stop_next  = stop_reg;
        step_next  = step_reg;
        dwell_next = dwell_reg;
        cont_next  = cont_reg;
        cnt_next   = cnt_reg;
        freq_next  = freq_reg;
        stb_next   = 1'b0;
        wrap_next  = 1'b0;
        sum        = {1'b0, freq_reg} + {1'b0, step_reg};

        // Config is only accepted while cfg_ready is high (IDLE/ARMED).
        if (cfg_valid && (state_reg == IDLE || state_reg == ARMED)) begin
            start_next = cfg_start;
            stop_next  = cfg_stop;
            step_next  = cfg_step;
            dwell_next = cfg_dwell;
            cont_next  = cfg_cont;
        end

        case (state_reg)
            IDLE: begin
                if (cfg_valid)
                    state_next = ARMED;
            end
            ARMED: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (go) begin
                    // A config offered with go takes effect for this sweep.
                    state_next = SWEEP;
                    freq_next  = cfg_valid ? cfg_start : start_reg;
                    cnt_next   = '0;
                    stb_next   = 1'b1;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_next = IDLE;
                    freq_next  = '0;
                    cnt_next   = '0;
                end else if (cnt_reg == dwell_reg) begin
                    cnt_next = '0;
                    if (step_reg != '0 && sum <= {1'b0, stop_reg}) begin
                        freq_next = sum[FW-1:0];
                        stb_next  = 1'b1;
                    end else if (cont_reg) begin
                        freq_next = start_reg;
                        stb_next  = 1'b1;
                        wrap_next = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    cnt_next = cnt_reg + DW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign freq_ctrl  = freq_reg;
    assign step_stb   = stb_reg;
    assign wrap       = wrap_reg;
    assign busy       = (state_reg == SWEEP);
    assign sweep_done = (state_reg == DONE);
    assign cfg_ready  = (state_reg == IDLE) || (state_reg == ARMED);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: a cycle-vector table for the single and
// top-of-range sweeps, then hand-written sequences for the multi-cycle cases.
module tb_dds_sweep_ctrl;

    localparam int FW = 11;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [FW-1:0] cfg_start = '0;
    logic [FW-1:0] cfg_stop = '0;
    logic [FW-1:0] cfg_step = '0;
    logic [DW-1:0] cfg_dwell = '0;
    logic          cfg_cont = 1'b0;
    logic          go = 1'b0;
    logic          abort = 1'b0;
    logic [FW-1:0] freq_ctrl;
    logic          step_stb;
    logic          busy;
    logic          wrap;
    logic          sweep_done;

    int n_checks = 0;
    int n_fail = 0;

    dds_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
        .cfg_dwell(cfg_dwell), .cfg_cont(cfg_cont),
        .go(go), .abort(abort),
        .freq_ctrl(freq_ctrl), .step_stb(step_stb), .busy(busy),
        .wrap(wrap), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rstn; bit cv; int start; int stop; int stp; int dwell; bit cont; bit go; bit ab;
        int efreq; bit estb; bit ebusy; bit ewrap; bit edone; bit erdy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit rstn, bit cv, int start, int stop, int stp, int dwell,
                                bit cont, bit g, bit ab, int efreq, bit estb, bit ebusy,
                                bit ewrap, bit edone, bit erdy);
        vec_t v;
        v.rstn = rstn; v.cv = cv; v.start = start; v.stop = stop; v.stp = stp;
        v.dwell = dwell; v.cont = cont; v.go = g; v.ab = ab;
        v.efreq = efreq; v.estb = estb; v.ebusy = ebusy; v.ewrap = ewrap;
        v.edone = edone; v.erdy = erdy;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and compare every output just after the edge.
    task automatic cyc(input string nm, input bit rstn, input bit cv, input int start,
                       input int stop, input int stp, input int dwell, input bit cont,
                       input bit g, input bit ab, input int efreq, input bit estb,
                       input bit ebusy, input bit ewrap, input bit edone, input bit erdy);
        rst       = rstn;
        cfg_valid = cv;
        cfg_start = FW'(start);
        cfg_stop  = FW'(stop);
        cfg_step  = FW'(stp);
        cfg_dwell = DW'(dwell);
        cfg_cont  = cont;
        go        = g;
        abort     = ab;
        @(posedge clk);
        #1;
        $display("txn %s: rst=%0b cv=%0b go=%0b abort=%0b -> freq=%0d stb=%0b busy=%0b wrap=%0b done=%0b ready=%0b",
                 nm, rstn, cv, g, ab, freq_ctrl, step_stb, busy, wrap, sweep_done, cfg_ready);
        check({nm, " freq_ctrl"},  32'(freq_ctrl),  32'(efreq));
        check({nm, " step_stb"},   32'(step_stb),   32'(estb));
        check({nm, " busy"},       32'(busy),       32'(ebusy));
        check({nm, " wrap"},       32'(wrap),       32'(ewrap));
        check({nm, " sweep_done"}, 32'(sweep_done), 32'(edone));
        check({nm, " cfg_ready"},  32'(cfg_ready),  32'(erdy));
    endtask

    task automatic idle(input string nm, input int efreq, input bit estb, input bit ebusy,
                        input bit ewrap, input bit edone, input bit erdy);
        cyc(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, efreq, estb, ebusy, ewrap, edone, erdy);
    endtask

    int cont_exp[3];

    initial begin
        cont_exp[0] = 0; cont_exp[1] = 10; cont_exp[2] = 20;

        //              rstn cv start stop stp dw cont go ab | freq stb busy wrap done rdy
        vt.push_back(mk(0, 0,    0,   0,  0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 1)); // reset
        vt.push_back(mk(1, 1,  100, 130, 10, 3, 0, 0, 0,    0, 0, 0, 0, 0, 1)); // config -> ARMED
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 1, 0,  100, 1, 1, 0, 0, 0)); // go edge 0
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  100, 0, 1, 0, 0, 0)); // edge 1
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  100, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  100, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  110, 1, 1, 0, 0, 0)); // edge 4
        vt.push_back(mk(1, 1,  999,2000,  1, 0, 1, 0, 0,  110, 0, 1, 0, 0, 0)); // cfg in SWEEP ignored
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  110, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  110, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  120, 1, 1, 0, 0, 0)); // edge 8
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  120, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  120, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  120, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  130, 1, 1, 0, 0, 0)); // edge 12
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  130, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  130, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  130, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  130, 0, 0, 0, 1, 0)); // edge 16 DONE
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0,  130, 0, 0, 0, 0, 1)); // edge 17 IDLE
        vt.push_back(mk(1, 1, 2040,2047,  5, 0, 0, 0, 0,  130, 0, 0, 0, 0, 1)); // top-of-range cfg
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 1, 0, 2040, 1, 1, 0, 0, 0));
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0, 2045, 1, 1, 0, 0, 0));
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 0, 0, 2045, 0, 0, 0, 1, 0)); // 2050 > stop
        vt.push_back(mk(1, 0,    0,   0,  0, 0, 0, 1, 0, 2045, 0, 0, 0, 0, 1)); // go in IDLE ignored

        for (int i = 0; i < vt.size(); i++) begin
            cyc($sformatf("vec%0d", i), vt[i].rstn, vt[i].cv, vt[i].start, vt[i].stop,
                vt[i].stp, vt[i].dwell, vt[i].cont, vt[i].go, vt[i].ab, vt[i].efreq,
                vt[i].estb, vt[i].ebusy, vt[i].ewrap, vt[i].edone, vt[i].erdy);
        end

        // go and abort together in ARMED: abort wins, freq_ctrl keeps its value
        cyc("gab_cfg", 1, 1, 50, 60, 5, 0, 0, 0, 0, 2045, 0, 0, 0, 0, 1);
        cyc("gab_both", 1, 0, 0, 0, 0, 0, 0, 1, 1, 2045, 0, 0, 0, 0, 1);
        cyc("gab_go_idle", 1, 0, 0, 0, 0, 0, 0, 1, 0, 2045, 0, 0, 0, 0, 1);

        // re-config in ARMED: the second config is the one used at go
        cyc("rcfg_a", 1, 1, 50, 60, 5, 0, 0, 0, 0, 2045, 0, 0, 0, 0, 1);
        cyc("rcfg_b", 1, 1, 70, 70, 1, 2, 0, 0, 0, 2045, 0, 0, 0, 0, 1);
        cyc("rcfg_go", 1, 0, 0, 0, 0, 0, 0, 1, 0, 70, 1, 1, 0, 0, 0);
        idle("rcfg_e1", 70, 0, 1, 0, 0, 0);
        idle("rcfg_e2", 70, 0, 1, 0, 0, 0);
        idle("rcfg_e3", 70, 0, 0, 0, 1, 0);
        idle("rcfg_e4", 70, 0, 0, 0, 0, 1);

        // step = 0: single dwell at start then done
        cyc("step0_cfg", 1, 1, 300, 400, 0, 1, 0, 0, 0, 70, 0, 0, 0, 0, 1);
        cyc("step0_go", 1, 0, 0, 0, 0, 0, 0, 1, 0, 300, 1, 1, 0, 0, 0);
        idle("step0_e1", 300, 0, 1, 0, 0, 0);
        idle("step0_e2", 300, 0, 0, 0, 1, 0);
        idle("step0_e3", 300, 0, 0, 0, 0, 1);

        // continuous sweep 0,10,20 with wrap, then abort mid-sweep
        cyc("cont_cfg", 1, 1, 0, 20, 10, 1, 1, 0, 0, 300, 0, 0, 0, 0, 1);
        cyc("cont_go", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        for (int e = 1; e <= 13; e++) begin
            idle($sformatf("cont_e%0d", e), cont_exp[(e / 2) % 3], (e % 2) == 0, 1,
                 ((e % 2) == 0) && (((e / 2) % 3) == 0), 0, 0);
        end
        cyc("cont_abort", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        idle("cont_post", 0, 0, 0, 0, 0, 1);

        // reset mid-sweep, then go must be ignored because the block is back in IDLE
        cyc("rst_cfg", 1, 1, 100, 130, 10, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("rst_go", 1, 0, 0, 0, 0, 0, 0, 1, 0, 100, 1, 1, 0, 0, 0);
        idle("rst_e1", 100, 0, 1, 0, 0, 0);
        idle("rst_e2", 100, 0, 1, 0, 0, 0);
        cyc("rst_apply", 0, 1, 5, 6, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        cyc("rst_go_idle", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
